gost_multiround: RTL and testbench
==================================

Name: gost_multiround

Overview:
- Parametrised successor to the single-round-per-clock GOST R 34.12-2015 Magma core (64-bit block, 256-bit key).
- Computes ROUNDS_PER_CLK Feistel rounds combinationally per clock, trading area for latency (32/ROUNDS_PER_CLK run cycles).
- Same start/done level handshake as the existing core, plus a busy flag and non-retrigger protection.
- Sits under the SD data-path encryption layer as a drop-in for the existing cipher.

Parameters:
- ROUNDS_PER_CLK, 1, rounds evaluated per clock. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.

Ports:
- iclk      input   1    system clock, rising edge.
- irst      input   1    synchronous reset, active-high.
- istart    input   1    operation request, level; sampled in IDLE.
- ienc_dec  input   1    0 = encrypt, 1 = decrypt; latched on accept.
- ikey      input   256  key; latched on accept.
- iblock    input   64   input block; latched on accept.
- oblock    output  64   result; valid while odone=1.
- odone     output  1    high in DONE state.
- obusy     output  1    high in RUN state.

Behaviour:
- Reset (irst=1 at a rising edge): state=IDLE, oblock=0, odone=0, obusy=0, round counter=0. Applies in any state, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: if istart=1, latch ikey, iblock and ienc_dec, set counter=0, go to RUN (accept edge N). Otherwise stay.
  - RUN: each edge applies ROUNDS_PER_CLK rounds to state {hi,lo} and adds ROUNDS_PER_CLK to the counter. istart, ikey, iblock and ienc_dec are ignored. On the edge that completes round 32 (edge N+32/ROUNDS_PER_CLK): oblock={lo,hi} (final swap undone), go to DONE.
  - DONE: odone=1. If istart=0, go to IDLE (odone falls after that edge). If istart=1, stay in DONE; a held istart never retriggers.
- Latency: odone is first seen high after edge N+32/R. For R=1 that is 32 edges after accept; for R=8 it is 4 edges.
- obusy=1 exactly in RUN. odone=1 exactly in DONE. They are never both high.
- oblock changes only at completion or reset, and holds its value through IDLE and the next RUN.
- Key schedule: K1=key[255:224] … K8=key[31:0].
  - Encrypt, round r=0..31: rounds 0-23 use K(r mod 8 + 1); rounds 24-31 use K(8 - r mod 8).
  - Decrypt: round r uses the encrypt key of round 31-r.
- Round on state {hi,lo}, 32-bit halves: new hi=lo; new lo=hi XOR g(lo,K).
  - g(a,K) = ROTL11(S(a + K mod 2^32)).
  - S maps nibble i (bits 4i+3:4i) through π'i of GOST R 34.12-2015 §5.1.1, i=0..7.
- The round counter is 5 bits wide and wraps from 32 to 0; completion is detected on that wrap edge.

Test Plan:
- Encrypt, R=1: key FFEEDDCCBBAA99887766554433221100F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, iblock FEDCBA9876543210, istart=1 -> obusy high for 32 cycles, then odone=1, oblock=4EE901E5C2D8CA3D.
- Decrypt, R=1 and R=8, same key: iblock 4EE901E5C2D8CA3D, ienc_dec=1 -> oblock=FEDCBA9876543210. odone rises 32 edges (R=1) or 4 edges (R=8) after accept.
- Held start: keep istart=1 for 10 cycles after odone -> state stays DONE, oblock is stable, no new RUN. Drop istart -> IDLE next edge, odone=0.
- Ignored inputs: change iblock to 0 and ienc_dec to 1 during RUN -> result is still 4EE901E5C2D8CA3D.
- Reset mid-op: assert irst at run cycle 10 -> after that edge odone=0, obusy=0, oblock=0. A following encrypt gives the correct ciphertext.
- Back-to-back: encrypt, drop istart for 1 cycle, then decrypt -> both results correct, and oblock holds the previous value until the second completion.

Source files
------------

// File: rtl/gost_multiround.sv
// rtl/gost_multiround.sv - GOST R 34.12-2015 Magma block cipher, ROUNDS_PER_CLK Feistel rounds per clock
module gost_multiround #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         istart,
  input  logic         ienc_dec,
  input  logic [255:0] ikey,
  input  logic [63:0]  iblock,
  output logic [63:0]  oblock,
  output logic         odone,
  output logic         obusy
);

  if (!(ROUNDS_PER_CLK inside {1, 2, 4, 8})) begin : g_bad_rounds
    $error("gost_multiround: ROUNDS_PER_CLK must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] PI [8][16] = '{
    '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,  4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1},
    '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
    '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13, 4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0},
    '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,  4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
    '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13, 4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
    '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10, 4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0},
    '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12, 4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7},
    '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,  4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2}
  };

  function automatic logic [31:0] g_func(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] sum;
    logic [31:0] s;
    sum = a + k;
    for (int i = 0; i < 8; i++) s[4*i +: 4] = PI[i][sum[4*i +: 4]];
    return {s[20:0], s[31:21]};
  endfunction

  // Decrypt round r takes encrypt round 31-r, which is ~r in 5 bits.
  function automatic logic [31:0] round_key(input logic [255:0] key, input logic dec,
                                            input logic [4:0] r);
    logic [4:0] er;
    logic [2:0] idx;
    er  = dec ? ~r : r;
    idx = (er < 5'd24) ? er[2:0] : ~er[2:0];
    return key[(7 - idx) * 32 +: 32];
  endfunction

  state_t        state, state_nx;
  logic [255:0]  key_q;
  logic          dec_q;
  logic [31:0]   hi_q, lo_q, hi_nx, lo_nx;
  logic [4:0]    cnt_q;
  logic          last;

  always_comb begin
    logic [31:0] h, l, t;
    h = hi_q;
    l = lo_q;
    for (int k = 0; k < ROUNDS_PER_CLK; k++) begin
      t = h ^ g_func(l, round_key(key_q, dec_q, cnt_q + 5'(k)));
      h = l;
      l = t;
    end
    hi_nx = h;
    lo_nx = l;
  end

  assign last = ({1'b0, cnt_q} + 6'(ROUNDS_PER_CLK)) == 6'd32;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (istart) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (!istart) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state  <= IDLE;
      oblock <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && istart) begin
        key_q <= ikey;
        dec_q <= ienc_dec;
        hi_q  <= iblock[63:32];
        lo_q  <= iblock[31:0];
        cnt_q <= '0;
      end else if (state == RUN) begin
        hi_q  <= hi_nx;
        lo_q  <= lo_nx;
        cnt_q <= cnt_q + 5'(ROUNDS_PER_CLK);
        if (last) oblock <= {lo_nx, hi_nx};
      end
    end
  end

  assign odone = (state == DONE);
  assign obusy = (state == RUN);

endmodule

// File: tb/tb_gost_multiround.sv
// tb/tb_gost_multiround.sv - directed vectors for gost_multiround at R=1 and R=8
module tb_gost_multiround;

  localparam logic [255:0] KEY = 256'hFFEEDDCCBBAA99887766554433221100F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
  localparam logic [63:0]  PT  = 64'hFEDCBA9876543210;
  localparam logic [63:0]  CT  = 64'h4EE901E5C2D8CA3D;

  typedef struct {
    logic        sel;
    logic        ed;
    logic [63:0] blk;
    int          lat;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start1, start8, enc_dec, sel;
  logic [255:0] key;
  logic [63:0] blk_in;
  logic [63:0] oblock1, oblock8, oblock_m;
  logic        done1, done8, busy1, busy8, done_m, busy_m;
  logic [63:0] last1, last8;
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        vecs[4];

  gost_multiround #(.ROUNDS_PER_CLK(1)) dut1 (
    .iclk(clk), .irst(rst), .istart(start1), .ienc_dec(enc_dec), .ikey(key),
    .iblock(blk_in), .oblock(oblock1), .odone(done1), .obusy(busy1)
  );

  gost_multiround #(.ROUNDS_PER_CLK(8)) dut8 (
    .iclk(clk), .irst(rst), .istart(start8), .ienc_dec(enc_dec), .ikey(key),
    .iblock(blk_in), .oblock(oblock8), .odone(done8), .obusy(busy8)
  );

  assign oblock_m = sel ? oblock8 : oblock1;
  assign done_m   = sel ? done8 : done1;
  assign busy_m   = sel ? busy8 : busy1;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves istart high with the selected core in DONE.
  task automatic do_op(input logic s, input logic ed, input logic [63:0] blk,
                       input int lat, input logic [63:0] exp, input string nm);
    int edges, busy_bad, hold_bad;
    logic [63:0] prev;
    @(negedge clk);
    sel = s; enc_dec = ed; blk_in = blk;
    if (s) start8 = 1'b1; else start1 = 1'b1;
    prev = s ? last8 : last1;
    @(posedge clk); #1;
    edges = 0; busy_bad = 0; hold_bad = 0;
    while (!done_m && edges < 200) begin
      if (!busy_m) busy_bad++;
      if (oblock_m !== prev) hold_bad++;
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, " latency"}, 64'(edges), 64'(lat));
    chk({nm, " busy during run"}, 64'(busy_bad), 64'd0);
    chk({nm, " oblock hold"}, 64'(hold_bad), 64'd0);
    chk({nm, " result"}, oblock_m, exp);
    chk({nm, " busy in done"}, 64'(busy_m), 64'd0);
    if (s) last8 = exp; else last1 = exp;
  endtask

  task automatic drop_start(input string nm);
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk({nm, " done after drop"}, 64'(done_m), 64'd0);
    chk({nm, " busy after drop"}, 64'(busy_m), 64'd0);
  endtask

  initial begin
    int edges;
    logic [63:0] held;

    vecs[0] = '{sel: 1'b0, ed: 1'b0, blk: PT, lat: 32, exp: CT};
    vecs[1] = '{sel: 1'b0, ed: 1'b1, blk: CT, lat: 32, exp: PT};
    vecs[2] = '{sel: 1'b1, ed: 1'b1, blk: CT, lat: 4,  exp: PT};
    vecs[3] = '{sel: 1'b1, ed: 1'b0, blk: PT, lat: 4,  exp: CT};

    rst = 1'b1; start1 = 1'b0; start8 = 1'b0; enc_dec = 1'b0; sel = 1'b0;
    key = KEY; blk_in = '0; last1 = '0; last8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset oblock r1", oblock1, 64'd0);
    chk("reset done r1", 64'(done1), 64'd0);
    chk("reset busy r1", 64'(busy1), 64'd0);
    chk("reset oblock r8", oblock8, 64'd0);
    chk("reset done r8", 64'(done8), 64'd0);
    chk("reset busy r8", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].sel, vecs[i].ed, vecs[i].blk, vecs[i].lat, vecs[i].exp, $sformatf("vec%0d", i));
      drop_start($sformatf("vec%0d", i));
    end

    // Held start: DONE must persist without retriggering.
    do_op(1'b0, 1'b0, PT, 32, CT, "held");
    held = oblock1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("held done", 64'(done1), 64'd1);
      chk("held busy", 64'(busy1), 64'd0);
      chk("held oblock", oblock1, held);
    end
    drop_start("held");

    // Inputs changed during RUN must not affect the result.
    @(negedge clk);
    sel = 1'b0; enc_dec = 1'b0; blk_in = PT; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk_in = '0; enc_dec = 1'b1;
    edges = 0;
    @(posedge clk); #1;
    while (!done1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("ignored inputs latency", 64'(edges), 64'd31);
    chk("ignored inputs result", oblock1, CT);
    drop_start("ignored");

    // Reset at run cycle 10 discards the operation.
    @(negedge clk);
    sel = 1'b0; enc_dec = 1'b1; blk_in = CT; start1 = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start1 = 1'b0;
    @(posedge clk); #1;
    chk("midrst done", 64'(done1), 64'd0);
    chk("midrst busy", 64'(busy1), 64'd0);
    chk("midrst oblock", oblock1, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last1 = '0;
    do_op(1'b0, 1'b0, PT, 32, CT, "after reset");
    drop_start("after reset");

    // Back-to-back: one idle cycle between encrypt and decrypt.
    do_op(1'b0, 1'b0, PT, 32, CT, "b2b enc");
    drop_start("b2b enc");
    do_op(1'b0, 1'b1, CT, 32, PT, "b2b dec");
    drop_start("b2b dec");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
